handshake_fifo_mc: RTL and testbench
====================================

// Module: handshake_fifo_mc
// PURPOSE
//  Multi-channel REQ/ACK FIFO: CHANNELS independent logical queues share one synchronous RAM,
//  partitioned into CHANNELS equal regions of DEPTH entries. Producer tags each word with a channel ID.
//  A single output port drains non-empty channels via an arbiter. Next-generation handshake FIFO
//  for merging multiple request streams (e.g. per-core memory requests) into one consumer.
// PARAMETERS
//  WIDTH     32  data width in bits
//  DEPTH     64  entries per channel; power of 2, >=2
//  CHANNELS  4   logical channels; power of 2, >=2
// PORTS
//  clk          in   1                   clock; all logic rising-edge
//  async_rst_n  in   1                   reset, asynchronous assert, active-low
//  clk_en       in   1                   global enable; when 0 no state changes, no ACK, no transfers
//  InputREQ     in   1                   producer has word
//  InputACK     out  1                   word accepted this cycle
//  InputChan    in   $clog2(CHANNELS)    destination channel of InputData
//  InputData    in   WIDTH               write data
//  OutputREQ    out  1                   OutputData/OutputChan valid
//  OutputACK    in   1                   consumer takes word
//  OutputChan   out  $clog2(CHANNELS)    source channel of OutputData
//  OutputData   out  WIDTH               read data
//  ChanFull     out  CHANNELS            per-channel full flags
//  ChanEmpty    out  CHANNELS            per-channel empty flags (counts RAM contents only)
// BEHAVIOUR
//  - Reset: all wr/rd pointers 0, counts 0, OutputREQ=0, OutputChan=0, OutputData=0, ChanFull=0,
//    ChanEmpty=all 1s, arbiter pointer=0. Reset mid-operation discards all queued data, incl. output reg.
//  - Transfer = REQ && ACK in the same cycle with clk_en=1. REQ must hold data stable until ACK.
//  - InputACK = clk_en && InputREQ && !ChanFull[InputChan] (combinational). Accepted word written at
//    RAM addr {InputChan, wr_ptr[InputChan]}; wr_ptr wraps modulo DEPTH.
//  - Per-channel count is $clog2(DEPTH)+1 bits; full = (count==DEPTH), empty = (count==0).
//  - Output stage: one register (RAM read register) + valid flag. Read issue condition in cycle t:
//    clk_en && (!OutputREQ || OutputACK) && some channel has count>0. Arbiter picks channel g,
//    rd_ptr[g]++ and count[g]-- at edge; OutputData/OutputChan/OutputREQ=1 valid after that edge.
//  - If issue condition false and OutputACK taken, OutputREQ drops to 0 next cycle.
//  - Sustained throughput 1 word/cycle when consumer ACKs continuously and any channel non-empty.
//  - Latency: input transfer at edge e -> count visible at e; read issued in following cycle ->
//    OutputREQ high 2 cycles after input handshake cycle (empty FIFO).
//  - Simultaneous write and read-issue on same channel: count unchanged; a channel at count 0 is not
//    eligible for read in the same cycle it is written (no bypass). Full channel freed by read in
//    cycle t accepts input from cycle t+1 (InputACK uses registered full).
//  - Arbitration (default): round-robin; pointer advances to g+1 mod CHANNELS after a grant to g.
//  - Ordering: per-channel FIFO order strictly preserved; no ordering across channels.
// CONFIGURATION
//  HANDSHAKE_FIFO_MC_STRICT_PRIO_EN defined: fixed priority, lowest non-empty channel index always
//    wins; arbiter pointer logic removed. Undefined: round-robin as above. Ports identical both ways.
// STRUCTURE
//  - Package handshake_fifo_mc_pkg: chan_t, ptr_t, count_t typedef helpers (parameterised via
//    localparam functions for clog2 widths), arbitration enum {ARB_RR, ARB_PRIO}.
//  - Sub-module mc_rr_arbiter (CHANNELS-wide request -> one-hot grant + index, round-robin pointer,
//    strict-priority under the macro). RAM inferred in top as WIDTH x (CHANNELS*DEPTH), 1R1W sync.
// TESTING
//  1. Reset, then write 0xA5 to ch2 -> InputACK=1 same cycle; OutputREQ=1, OutputChan=2,
//     OutputData=0xA5 two cycles later; ChanEmpty=4'b1111 after drain.
//  2. Fill ch1 with 64 words, hold OutputACK=0 -> ChanFull[1]=1, 65th InputREQ gets InputACK=0;
//     other channels still accept.
//  3. Load ch0..ch3 with 3 words each, OutputACK=1 constant -> OutputChan sequence 0,1,2,3,0,1,2,3,...
//     at 1 word/cycle, per-channel data order preserved (strict-prio build: 0,0,0,1,1,1,...).
//  4. Continuous write+read on ch3 across >2*DEPTH words -> wr/rd pointer wrap, no loss/duplication,
//    count stays stable.
//  5. Random OutputACK backpressure, OutputData checked stable while OutputREQ=1 && !OutputACK.
//  6. Assert async_rst_n low mid-burst (between edges) -> OutputREQ=0 immediately, all ChanEmpty=1;
//    clk_en=0 for 5 cycles -> no ACKs, no state change.

Source files
------------

// File: rtl/handshake_fifo_mc_pkg.sv
// Shared types and width helpers for the multi-channel handshake FIFO.
// Optional build macro: HANDSHAKE_FIFO_MC_STRICT_PRIO_EN (fixed-priority arbitration).
package handshake_fifo_mc_pkg;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_DEPTH    = 64;
    localparam int DEF_CHANNELS = 4;

    // Index width that never collapses to zero bits
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Occupancy counter needs one extra bit so that DEPTH itself is representable
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef logic [idx_width(DEF_CHANNELS)-1:0] chan_t;
    typedef logic [idx_width(DEF_DEPTH)-1:0]    ptr_t;
    typedef logic [count_width(DEF_DEPTH)-1:0]  count_t;

    typedef enum logic {
        ARB_RR   = 1'b0,
        ARB_PRIO = 1'b1
    } arb_mode_e;

endpackage

// File: rtl/mc_rr_arbiter.sv
// Channel arbiter: picks one requesting channel, reported as one-hot grant plus index.
// Default build is round-robin; with HANDSHAKE_FIFO_MC_STRICT_PRIO_EN the lowest
// requesting index always wins and the rotating pointer is not built.
module mc_rr_arbiter
    import handshake_fifo_mc_pkg::*;
#(
    parameter  int CHANNELS = DEF_CHANNELS,
    localparam int CW       = idx_width(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                advance,
    input  logic [CHANNELS-1:0] req,
    output logic [CHANNELS-1:0] grant,
    output logic [CW-1:0]       grant_idx,
    output logic                any_req
);

    // One-hot view of the chosen index, empty when nobody asks
    always_comb begin
        any_req = |req;
        grant   = any_req ? (CHANNELS'(1) << grant_idx) : '0;
    end

`ifdef HANDSHAKE_FIFO_MC_STRICT_PRIO_EN

    // Scan downwards so the lowest requesting channel is the last one written
    always_comb begin
        grant_idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (req[i]) grant_idx = CW'(i);
        end
    end

`else

    logic [CW-1:0] ptr_q;
    logic [CW-1:0] ptr_d;
    logic [CW-1:0] cand;
    logic          found;

    // Search starting at the pointer; channel count is a power of two so the index wraps for free
    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cand = ptr_q + CW'(i);
            if (!found && req[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // The channel after the one just served gets first look next time
    always_comb begin
        ptr_d = advance ? (grant_idx + CW'(1)) : ptr_q;
    end

    // Rotating pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

`endif

endmodule

// File: rtl/handshake_fifo_mc.sv
// Multi-channel REQ/ACK FIFO: CHANNELS logical queues in one shared 1R1W RAM,
// drained through an arbiter into a single registered output port.
// Optional build macro: HANDSHAKE_FIFO_MC_STRICT_PRIO_EN (fixed-priority drain order).
module handshake_fifo_mc
    import handshake_fifo_mc_pkg::*;
#(
    parameter  int WIDTH    = DEF_WIDTH,
    parameter  int DEPTH    = DEF_DEPTH,
    parameter  int CHANNELS = DEF_CHANNELS,
    localparam int CW       = idx_width(CHANNELS),
    localparam int PW       = idx_width(DEPTH),
    localparam int CNTW     = count_width(DEPTH)
) (
    input  logic                clk,
    input  logic                async_rst_n,
    input  logic                clk_en,
    input  logic                InputREQ,
    output logic                InputACK,
    input  logic [CW-1:0]       InputChan,
    input  logic [WIDTH-1:0]    InputData,
    output logic                OutputREQ,
    input  logic                OutputACK,
    output logic [CW-1:0]       OutputChan,
    output logic [WIDTH-1:0]    OutputData,
    output logic [CHANNELS-1:0] ChanFull,
    output logic [CHANNELS-1:0] ChanEmpty
);

    logic [WIDTH-1:0]    mem [CHANNELS*DEPTH];

    logic [CNTW-1:0]     count_q  [CHANNELS];
    logic [CNTW-1:0]     count_d  [CHANNELS];
    logic [PW-1:0]       wr_ptr_q [CHANNELS];
    logic [PW-1:0]       wr_ptr_d [CHANNELS];
    logic [PW-1:0]       rd_ptr_q [CHANNELS];
    logic [PW-1:0]       rd_ptr_d [CHANNELS];

    logic                out_valid_q, out_valid_d;
    logic [CW-1:0]       out_chan_q,  out_chan_d;
    logic [WIDTH-1:0]    out_data_q,  out_data_d;

    logic [CHANNELS-1:0] full, nonempty, grant;
    logic [CW-1:0]       grant_idx;
    logic                any_req, issue, wr_en;
    logic [WIDTH-1:0]    rd_word;

    // Flags come straight from registered counts, so a word written this cycle is not yet readable
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            full[c]     = (count_q[c] == CNTW'(DEPTH));
            nonempty[c] = (count_q[c] != '0);
        end
        ChanFull  = full;
        ChanEmpty = ~nonempty;
    end

    // Accept a word when enabled and its channel is not full; read when the output slot is free or leaving
    always_comb begin
        InputACK = clk_en && InputREQ && !full[InputChan];
        wr_en    = InputACK;
        issue    = clk_en && (!out_valid_q || OutputACK) && any_req;
        rd_word  = mem[{grant_idx, rd_ptr_q[grant_idx]}];
    end

    mc_rr_arbiter #(
        .CHANNELS (CHANNELS)
    ) u_arb (
        .clk       (clk),
        .rst_n     (async_rst_n),
        .advance   (issue),
        .req       (nonempty),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_req   (any_req)
    );

    // Per-channel pointer and occupancy update; a write and a read on one channel cancel out
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            count_d[c]  = count_q[c];
            wr_ptr_d[c] = wr_ptr_q[c];
            rd_ptr_d[c] = rd_ptr_q[c];
            if (wr_en && (InputChan == CW'(c))) wr_ptr_d[c] = wr_ptr_q[c] + PW'(1);
            if (issue && grant[c])              rd_ptr_d[c] = rd_ptr_q[c] + PW'(1);
            if ((wr_en && (InputChan == CW'(c))) && !(issue && grant[c]))
                count_d[c] = count_q[c] + CNTW'(1);
            else if (!(wr_en && (InputChan == CW'(c))) && (issue && grant[c]))
                count_d[c] = count_q[c] - CNTW'(1);
        end
    end

    // Output register loads on a read issue and empties once the consumer takes it with nothing behind
    always_comb begin
        out_valid_d = out_valid_q;
        out_chan_d  = out_chan_q;
        out_data_d  = out_data_q;
        if (issue) begin
            out_valid_d = 1'b1;
            out_chan_d  = grant_idx;
            out_data_d  = rd_word;
        end else if (clk_en && OutputACK) begin
            out_valid_d = 1'b0;
        end
    end

    // Shared storage; each channel owns the region addressed by its index in the upper bits
    always_ff @(posedge clk) begin
        if (wr_en) mem[{InputChan, wr_ptr_q[InputChan]}] <= InputData;
    end

    // Control state, cleared asynchronously so a reset drops everything including the output word
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                count_q[c]  <= '0;
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
            end
            out_valid_q <= 1'b0;
            out_chan_q  <= '0;
            out_data_q  <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                count_q[c]  <= count_d[c];
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
            end
            out_valid_q <= out_valid_d;
            out_chan_q  <= out_chan_d;
            out_data_q  <= out_data_d;
        end
    end

    assign OutputREQ  = out_valid_q;
    assign OutputChan = out_chan_q;
    assign OutputData = out_data_q;

endmodule

// File: tb/tb_handshake_fifo_mc.sv
// Self-checking bench for handshake_fifo_mc: cycle vector table, per-channel scoreboard
// and directed multi-cycle sequences. Honours HANDSHAKE_FIFO_MC_STRICT_PRIO_EN for drain order.
module tb_handshake_fifo_mc;

    localparam int WIDTH    = 32;
    localparam int DEPTH    = 64;
    localparam int CHANNELS = 4;

    logic                clk = 1'b0;
    logic                async_rst_n;
    logic                clk_en;
    logic                InputREQ;
    logic                InputACK;
    logic [1:0]          InputChan;
    logic [WIDTH-1:0]    InputData;
    logic                OutputREQ;
    logic                OutputACK;
    logic [1:0]          OutputChan;
    logic [WIDTH-1:0]    OutputData;
    logic [CHANNELS-1:0] ChanFull;
    logic [CHANNELS-1:0] ChanEmpty;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] exp_q [CHANNELS][$];
    int               chan_seq [$];

    typedef struct {
        logic        en;
        logic        req;
        logic [1:0]  chan;
        logic [31:0] data;
        logic        oack;
        logic        exp_iack;
        logic        exp_oreq;
        logic [1:0]  exp_ochan;
        logic [31:0] exp_odata;
        logic [3:0]  exp_empty;
    } vec_t;

    vec_t        vecs [15];
    logic        pend, rreq;
    logic [1:0]  pc;
    logic [31:0] pd;
    int          exp_chan;

    handshake_fifo_mc #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .CHANNELS (CHANNELS)
    ) dut (
        .clk         (clk),
        .async_rst_n (async_rst_n),
        .clk_en      (clk_en),
        .InputREQ    (InputREQ),
        .InputACK    (InputACK),
        .InputChan   (InputChan),
        .InputData   (InputData),
        .OutputREQ   (OutputREQ),
        .OutputACK   (OutputACK),
        .OutputChan  (OutputChan),
        .OutputData  (OutputData),
        .ChanFull    (ChanFull),
        .ChanEmpty   (ChanEmpty)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic req, input logic [1:0] chan,
                                 input logic [31:0] data, input logic oack);
        @(negedge clk);
        clk_en    = en;
        InputREQ  = req;
        InputChan = chan;
        InputData = data;
        OutputACK = oack;
    endtask

    task automatic flushModel();
        for (int c = 0; c < CHANNELS; c++) exp_q[c].delete();
        chan_seq.delete();
    endtask

    task automatic doReset();
        @(negedge clk);
        async_rst_n = 1'b0;
        clk_en = 1'b1; InputREQ = 1'b0; OutputACK = 1'b0;
        flushModel();
        @(negedge clk);
        async_rst_n = 1'b1;
    endtask

    task automatic drain(input int max_cycles);
        int  k;
        bit  done;
        done = 1'b0;
        for (k = 0; k < max_cycles && !done; k++) begin
            applyStimulus(1'b1, 1'b0, 2'd0, 32'd0, 1'b1);
            #3;
            done = !OutputREQ && exp_q[0].size() == 0 && exp_q[1].size() == 0 &&
                   exp_q[2].size() == 0 && exp_q[3].size() == 0;
        end
        checkOutput("drain_done", done, 1'b1);
        checkOutput("drain_empty", ChanEmpty, 4'b1111);
        applyStimulus(1'b1, 1'b0, 2'd0, 32'd0, 1'b0);
    endtask

    // Scoreboard monitor: pushes accepted words, pops on output transfers, checks hold stability
    initial begin : monitor
        logic        hold;
        logic [31:0] hold_data;
        logic [1:0]  hold_chan;
        hold = 1'b0;
        hold_data = '0;
        hold_chan = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!async_rst_n) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    checkOutput("hold_req", OutputREQ, 1'b1);
                    checkOutput("hold_data", OutputData, hold_data);
                    checkOutput("hold_chan", OutputChan, hold_chan);
                end
                if (clk_en && InputREQ && InputACK) exp_q[InputChan].push_back(InputData);
                if (clk_en && OutputREQ && OutputACK) begin
                    chan_seq.push_back(int'(OutputChan));
                    if (exp_q[OutputChan].size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("[TB] FAIL scoreboard_unexpected: actual chan=%0d data=%0h required=no word",
                                 OutputChan, OutputData);
                    end else begin
                        checkOutput("scoreboard_data", OutputData, exp_q[OutputChan].pop_front());
                    end
                end
                hold      = OutputREQ && !(clk_en && OutputACK);
                hold_data = OutputData;
                hold_chan = OutputChan;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin : main
        vecs[0]  = '{1'b1, 1'b1, 2'd2, 32'hA5, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0,  4'b1111};
        vecs[1]  = '{1'b1, 1'b0, 2'd0, 32'h0,  1'b0, 1'b0, 1'b0, 2'd0, 32'h0,  4'b1011};
        vecs[2]  = '{1'b1, 1'b0, 2'd0, 32'h0,  1'b0, 1'b0, 1'b1, 2'd2, 32'hA5, 4'b1111};
        vecs[3]  = '{1'b1, 1'b0, 2'd0, 32'h0,  1'b1, 1'b0, 1'b1, 2'd2, 32'hA5, 4'b1111};
        vecs[4]  = '{1'b1, 1'b0, 2'd0, 32'h0,  1'b0, 1'b0, 1'b0, 2'd0, 32'h0,  4'b1111};
        vecs[5]  = '{1'b0, 1'b1, 2'd0, 32'h11, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0,  4'b1111};
        vecs[6]  = '{1'b0, 1'b1, 2'd0, 32'h11, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0,  4'b1111};
        vecs[7]  = '{1'b1, 1'b1, 2'd0, 32'h11, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0,  4'b1111};
        vecs[8]  = '{1'b0, 1'b0, 2'd0, 32'h0,  1'b0, 1'b0, 1'b0, 2'd0, 32'h0,  4'b1110};
        vecs[9]  = '{1'b0, 1'b0, 2'd0, 32'h0,  1'b1, 1'b0, 1'b0, 2'd0, 32'h0,  4'b1110};
        vecs[10] = '{1'b1, 1'b0, 2'd0, 32'h0,  1'b0, 1'b0, 1'b0, 2'd0, 32'h0,  4'b1110};
        vecs[11] = '{1'b0, 1'b0, 2'd0, 32'h0,  1'b1, 1'b0, 1'b1, 2'd0, 32'h11, 4'b1111};
        vecs[12] = '{1'b0, 1'b0, 2'd0, 32'h0,  1'b1, 1'b0, 1'b1, 2'd0, 32'h11, 4'b1111};
        vecs[13] = '{1'b1, 1'b0, 2'd0, 32'h0,  1'b1, 1'b0, 1'b1, 2'd0, 32'h11, 4'b1111};
        vecs[14] = '{1'b1, 1'b0, 2'd0, 32'h0,  1'b0, 1'b0, 1'b0, 2'd0, 32'h0,  4'b1111};

        async_rst_n = 1'b0;
        clk_en = 1'b0; InputREQ = 1'b0; InputChan = '0; InputData = '0; OutputACK = 1'b0;
        #1;
        checkOutput("reset_oreq", OutputREQ, 1'b0);
        checkOutput("reset_ochan", OutputChan, 2'd0);
        checkOutput("reset_odata", OutputData, 32'h0);
        checkOutput("reset_full", ChanFull, 4'b0000);
        checkOutput("reset_empty", ChanEmpty, 4'b1111);
        @(negedge clk);
        @(negedge clk);
        async_rst_n = 1'b1;

        $display("[TB] single word latency and clk_en vectors");
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].en, vecs[i].req, vecs[i].chan, vecs[i].data, vecs[i].oack);
            #3;
            checkOutput($sformatf("vec%0d_iack", i), InputACK, vecs[i].exp_iack);
            checkOutput($sformatf("vec%0d_oreq", i), OutputREQ, vecs[i].exp_oreq);
            checkOutput($sformatf("vec%0d_empty", i), ChanEmpty, vecs[i].exp_empty);
            if (vecs[i].exp_oreq) begin
                checkOutput($sformatf("vec%0d_ochan", i), OutputChan, vecs[i].exp_ochan);
                checkOutput($sformatf("vec%0d_odata", i), OutputData, vecs[i].exp_odata);
            end
        end

        $display("[TB] channel full with output stalled");
        doReset();
        applyStimulus(1'b1, 1'b1, 2'd0, 32'h100, 1'b0);
        #3 checkOutput("fill_pre_iack", InputACK, 1'b1);
        applyStimulus(1'b1, 1'b0, 2'd0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'd0, 32'h0, 1'b0);
        #3 checkOutput("fill_pre_oreq", OutputREQ, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 1'b1, 2'd1, 32'h1000 + i, 1'b0);
            #3 checkOutput($sformatf("fill_iack%0d", i), InputACK, 1'b1);
        end
        applyStimulus(1'b1, 1'b1, 2'd1, 32'hDEAD, 1'b0);
        #3;
        checkOutput("full_iack", InputACK, 1'b0);
        checkOutput("full_flags", ChanFull, 4'b0010);
        applyStimulus(1'b1, 1'b1, 2'd2, 32'h2000, 1'b0);
        #3 checkOutput("other_chan_iack", InputACK, 1'b1);
        applyStimulus(1'b1, 1'b1, 2'd1, 32'hDEAD, 1'b0);
        #3 checkOutput("still_full_iack", InputACK, 1'b0);
        drain(400);

        $display("[TB] arbitration order at full rate");
        doReset();
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < CHANNELS; c++) begin
                applyStimulus(1'b1, 1'b1, 2'(c), 32'h3000 + 32'(c * 16 + r), 1'b0);
                #3 checkOutput($sformatf("arb_load_iack_%0d_%0d", c, r), InputACK, 1'b1);
            end
        end
        chan_seq.delete();
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1'b1, 1'b0, 2'd0, 32'h0, 1'b1);
            #3 checkOutput($sformatf("arb_oreq%0d", k), OutputREQ, 1'b1);
        end
        applyStimulus(1'b1, 1'b0, 2'd0, 32'h0, 1'b0);
        #3;
        checkOutput("arb_oreq_end", OutputREQ, 1'b0);
        checkOutput("arb_count", chan_seq.size(), 12);
        for (int k = 0; k < 12 && k < chan_seq.size(); k++) begin
`ifdef HANDSHAKE_FIFO_MC_STRICT_PRIO_EN
            exp_chan = k / 3;
`else
            exp_chan = k % 4;
`endif
            checkOutput($sformatf("arb_seq%0d", k), chan_seq[k], exp_chan);
        end

        $display("[TB] streaming through channel 3 across pointer wrap");
        for (int i = 0; i < 2 * DEPTH + 22; i++) begin
            pd = $urandom;
            applyStimulus(1'b1, 1'b1, 2'd3, pd, 1'b1);
            #3 checkOutput($sformatf("stream_iack%0d", i), InputACK, 1'b1);
            if (i % 30 == 1) begin
                checkOutput($sformatf("stream_empty%0d", i), ChanEmpty, 4'b0111);
                checkOutput($sformatf("stream_full%0d", i), ChanFull, 4'b0000);
            end
        end
        drain(50);

        $display("[TB] random traffic with output backpressure");
        pend = 1'b0;
        pc = '0;
        pd = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pend) begin
                pc = 2'($urandom_range(0, 3));
                pd = $urandom;
            end
            rreq = pend || ($urandom_range(0, 3) != 0);
            applyStimulus(1'b1, rreq, pc, pd, 1'($urandom_range(0, 1)));
            #3;
            pend = rreq && !InputACK;
        end
        drain(1000);

        $display("[TB] asynchronous reset mid-burst, then clk_en held low");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b1, 2'(i % 2), 32'h4000 + i, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 2'd0, 32'h0, 1'b0);
        #3 checkOutput("burst_oreq", OutputREQ, 1'b1);
        @(negedge clk);
        #3;
        async_rst_n = 1'b0;
        flushModel();
        #1;
        checkOutput("midrst_oreq", OutputREQ, 1'b0);
        checkOutput("midrst_empty", ChanEmpty, 4'b1111);
        checkOutput("midrst_full", ChanFull, 4'b0000);
        checkOutput("midrst_odata", OutputData, 32'h0);
        checkOutput("midrst_ochan", OutputChan, 2'd0);
        @(negedge clk);
        @(negedge clk);
        async_rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 2'd1, 32'h55, 1'b1);
            #3;
            checkOutput($sformatf("gated_iack%0d", i), InputACK, 1'b0);
            checkOutput($sformatf("gated_empty%0d", i), ChanEmpty, 4'b1111);
            checkOutput($sformatf("gated_oreq%0d", i), OutputREQ, 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 2'd1, 32'h55, 1'b0);
        #3 checkOutput("post_rst_iack", InputACK, 1'b1);
        drain(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
